fir_ctrl: RTL and testbench

FIR computation sequencer for the filter core. After a `start` pulse it walks the input-sample RAM and the coefficient RAM, runs a multiply-accumulate for every output sample and writes Q15 results into the output RAM. It sits between the RAMs and the AXI slave: while `busy` is high it owns the RAM read and write ports, and the AXI-side multiplexer selects it.

---
 rtl/fir_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_fir_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl.sv
// fir_ctrl: FIR sequencer; walks sample/coefficient RAMs, accumulates x[n-k]*h[k], writes Q15 y[n].
// Latency: kmax_n+4 cycles per output sample; a run spans 2+sum(kmax_n+4) cycles including the start cycle.
// Backpressure: none; RAMs answer in exactly one cycle. Define FIR_CTRL_SAT_EN to saturate results and drive ovf.
module fir_ctrl #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int MAX_TAPS = 64,
  parameter int TAP_W    = $clog2(MAX_TAPS) + 1,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 0
) (
  input  logic              a_clk,
  input  logic              a_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] sample_count,
  input  logic [TAP_W-1:0]  tap_count,
  output logic              busy,
  output logic              done,
  output logic              x_rd_en,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_data,
  output logic              c_rd_en,
  output logic [TAP_W-2:0]  c_addr,
  input  logic [DATA_W-1:0] c_data,
  output logic              y_wr_en,
  output logic [ADDR_W-1:0] y_addr,
  output logic [DATA_W-1:0] y_data,
  output logic              ovf
);

  localparam int KW    = TAP_W - 1;
  localparam int PW    = 2 * DATA_W;
  localparam int ACC_W = PW + $clog2(MAX_TAPS);
  localparam int CW    = (ADDR_W > TAP_W) ? ADDR_W : TAP_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       n_q, n_d;          // current output sample index
  logic [ADDR_W-1:0]       n_cnt_q, n_cnt_d;  // latched N
  logic [TAP_W-1:0]        t_q, t_d;          // latched, clamped T
  logic [KW-1:0]           k_q, k_d;          // current tap index
  logic [KW-1:0]           kmax_q, kmax_d;    // last tap for this sample
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    pv_q, pv_d;        // RAM data this cycle belongs to a MAC read

  logic [TAP_W-1:0]        t_clamp;
  logic [CW-1:0]           n_ext;
  logic [CW-1:0]           tm1_ext;
  logic signed [PW-1:0]    x_ext;
  logic signed [PW-1:0]    c_ext;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] addend;
  logic [DATA_W-1:0]       res_dat;

  // Full-precision product of the RAM data, sign-extended into the accumulator width
  always_comb begin
    x_ext  = {{DATA_W{x_data[DATA_W-1]}}, x_data};
    c_ext  = {{DATA_W{c_data[DATA_W-1]}}, c_data};
    prod   = x_ext * c_ext;
    addend = '0;
    if (pv_q) begin
      addend = {{(ACC_W-PW){prod[PW-1]}}, prod};
    end
  end

  // Tap clamp and kmax = min(T-1, n) in a width wide enough for both operands
  always_comb begin
    t_clamp = tap_count;
    if (tap_count > TAP_W'(MAX_TAPS)) begin
      t_clamp = TAP_W'(MAX_TAPS);
    end
    n_ext   = CW'(n_q);
    tm1_ext = CW'(t_q) - CW'(1);
  end

  // Next-state and datapath update for the sequencer
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    n_cnt_d = n_cnt_q;
    t_d     = t_q;
    k_d     = k_q;
    kmax_d  = kmax_q;
    acc_d   = acc_q;
    pv_d    = (state_q == S_MAC);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((sample_count != '0) && (tap_count != '0)) begin
            n_cnt_d = sample_count;
            t_d     = t_clamp;
            n_d     = '0;
            state_d = S_CLR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CLR: begin
        acc_d   = '0;
        k_d     = '0;
        kmax_d  = KW'((n_ext < tm1_ext) ? n_ext : tm1_ext);
        state_d = S_MAC;
      end
      S_MAC: begin
        // First MAC cycle sees no valid data yet; addend is gated by pv_q
        acc_d = acc_q + addend;
        if (k_q == kmax_q) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        acc_d   = acc_q + addend;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (n_q == (n_cnt_q - ADDR_W'(1))) begin
          state_d = S_DONE;
        end else begin
          n_d     = n_q + ADDR_W'(1);
          state_d = S_CLR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and counters
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      n_cnt_q <= '0;
      t_q     <= '0;
      k_q     <= '0;
      kmax_q  <= '0;
      acc_q   <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      n_cnt_q <= n_cnt_d;
      t_q     <= t_d;
      k_q     <= k_d;
      kmax_q  <= kmax_d;
      acc_q   <= acc_d;
      pv_q    <= pv_d;
    end
  end

`ifdef FIR_CTRL_SAT_EN
  logic signed [ACC_W-1:0] acc_shr;
  logic                    res_sat;
  logic                    ovf_q, ovf_d;

  // Q15 result with saturation when the shifted value leaves the DATA_W range
  always_comb begin
    acc_shr = acc_q >>> (DATA_W - 1);
    res_sat = 1'b0;
    res_dat = acc_shr[DATA_W-1:0];
    if (acc_shr[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){acc_shr[ACC_W-1]}}) begin
      res_sat = 1'b1;
      res_dat = acc_shr[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // Sticky overflow: cleared by an accepted start, set by any clamped write
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == S_IDLE) && start) begin
      ovf_d = 1'b0;
    end else if ((state_q == S_WRITE) && res_sat) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow flag register
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  // Q15 result wraps: low DATA_W bits of acc >>> (DATA_W-1)
  always_comb begin
    res_dat = acc_q[PW-2:DATA_W-1];
  end

  assign ovf = 1'b0;
`endif

  // Output decode from registered state and counters; idle ports read as zero
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    x_rd_en = (state_q == S_MAC);
    c_rd_en = (state_q == S_MAC);
    y_wr_en = (state_q == S_WRITE);
    x_addr  = '0;
    c_addr  = '0;
    y_addr  = '0;
    y_data  = '0;
    if (state_q == S_MAC) begin
      x_addr = ADDR_W'(IN_BASE) + n_q - ADDR_W'(k_q);
      c_addr = k_q;
    end
    if (state_q == S_WRITE) begin
      y_addr = ADDR_W'(OUT_BASE) + n_q;
      y_data = res_dat;
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: randomized and directed runs of fir_ctrl against a sum-of-products reference model.
// RAMs are modelled with one-cycle read latency; expected writes go into a scoreboard queue.
// A monitor pops and compares on every y_wr_en; run-level checks cover length, strobes and ovf.
`timescale 1ns/1ps
module tb_fir_ctrl;

  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 16;
  localparam int MAX_TAPS = 64;
  localparam int TAP_W    = 7;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic              a_clk = 1'b0;
  logic              a_rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] sample_count = '0;
  logic [TAP_W-1:0]  tap_count = '0;
  logic              busy, done, x_rd_en, c_rd_en, y_wr_en, ovf;
  logic [ADDR_W-1:0] x_addr, y_addr;
  logic [TAP_W-2:0]  c_addr;
  logic [DATA_W-1:0] x_data, c_data, y_data;

  logic [15:0] x_mem [0:255];
  logic [15:0] c_mem [0:63];

  wr_t exp_q[$];
  int  vec = 0;
  int  err = 0;
  int  xr_cnt = 0;
  int  cr_cnt = 0;
  int  busy_cnt = 0;

  fir_ctrl dut (
    .a_clk(a_clk), .a_rst(a_rst), .start(start),
    .sample_count(sample_count), .tap_count(tap_count),
    .busy(busy), .done(done),
    .x_rd_en(x_rd_en), .x_addr(x_addr), .x_data(x_data),
    .c_rd_en(c_rd_en), .c_addr(c_addr), .c_data(c_data),
    .y_wr_en(y_wr_en), .y_addr(y_addr), .y_data(y_data),
    .ovf(ovf)
  );

  always #5 a_clk = ~a_clk;

  // One-cycle-latency RAM models
  always @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      x_data <= '0;
      c_data <= '0;
    end else begin
      if (x_rd_en) x_data <= x_mem[x_addr[7:0]];
      if (c_rd_en) c_data <= c_mem[c_addr];
    end
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vec++;
    if (act !== req) begin
      err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endfunction

  function automatic longint sx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // Monitor: strobe/busy counters and scoreboard comparison of every write
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge a_clk);
      if (!a_rst) begin
        if (x_rd_en) xr_cnt++;
        if (c_rd_en) cr_cnt++;
        if (busy) busy_cnt++;
        if (y_wr_en) begin
          if (exp_q.size() == 0) begin
            vec++;
            err++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", y_addr, y_data);
          end else begin
            e = exp_q.pop_front();
            chk("y_addr", 64'(y_addr), 64'(e.a));
            chk("y_data", 64'(y_data), 64'(e.d));
          end
        end
      end
    end
  end

  // Model the run, issue start, optionally re-pulse start mid-run, then check run-level results
  task automatic run(input int n_smp, input int n_tap, input int mid, input string tag, output int done_at);
    int     te, sum_k, sum_c, exp_done, km, ndone, xr0, cr0, b0;
    longint acc, sh;
    logic [15:0] yv;
    bit     eovf;
    wr_t    w;
    te = (n_tap > MAX_TAPS) ? MAX_TAPS : n_tap;
    sum_k = 0;
    sum_c = 0;
    eovf  = 1'b0;
    if (n_smp != 0 && n_tap != 0) begin
      for (int n = 0; n < n_smp; n++) begin
        km  = (te - 1 < n) ? te - 1 : n;
        acc = 0;
        for (int k = 0; k <= km; k++) acc += sx(x_mem[n-k]) * sx(c_mem[k]);
        sh = acc >>> 15;
`ifdef FIR_CTRL_SAT_EN
        if (sh > 32767) begin
          yv = 16'h7fff;
          eovf = 1'b1;
        end else if (sh < -32768) begin
          yv = 16'h8000;
          eovf = 1'b1;
        end else begin
          yv = sh[15:0];
        end
`else
        yv = sh[15:0];
`endif
        w.a = ADDR_W'(n);
        w.d = yv;
        exp_q.push_back(w);
        sum_k += km + 1;
        sum_c += km + 4;
      end
    end
    exp_done = 1 + sum_c;

    @(negedge a_clk);
    xr0 = xr_cnt;
    cr0 = cr_cnt;
    b0  = busy_cnt;
    sample_count = ADDR_W'(n_smp);
    tap_count    = TAP_W'(n_tap);
    start        = 1'b1;
    done_at = -1;
    ndone   = 0;
    for (int c = 1; c <= exp_done + 3; c++) begin
      @(negedge a_clk);
      if (c == 1) begin
        start = 1'b0;
        chk({tag, "_busy_first"}, 64'(busy), 64'd1);
      end
      if (mid > 1 && c == mid) begin
        start        = 1'b1;
        sample_count = ADDR_W'($urandom_range(1, 20));
        tap_count    = TAP_W'($urandom_range(1, 10));
      end
      if (mid > 1 && c == mid + 1) start = 1'b0;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
    end
    chk({tag, "_done_cycle"}, 64'(done_at), 64'(exp_done));
    chk({tag, "_done_pulses"}, 64'(ndone), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt - b0), 64'(exp_done));
    chk({tag, "_x_strobes"}, 64'(xr_cnt - xr0), 64'(sum_k));
    chk({tag, "_c_strobes"}, 64'(cr_cnt - cr0), 64'(sum_k));
    chk({tag, "_missing_writes"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'(eovf));
    exp_q.delete();
  endtask

  initial begin : stim
    int d;
    int nr, tr, mr;
    for (int i = 0; i < 256; i++) x_mem[i] = 16'($urandom);
    for (int i = 0; i < 64; i++)  c_mem[i] = 16'($urandom);

    // Reset state
    repeat (3) @(negedge a_clk);
    chk("reset_outputs", 64'({busy, done, x_rd_en, c_rd_en, y_wr_en, ovf, x_addr, c_addr, y_addr, y_data}), 64'd0);
    a_rst = 1'b0;
    @(negedge a_clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Impulse response
    x_mem[0] = 16'h7fff; x_mem[1] = 16'h0000; x_mem[2] = 16'h0000; x_mem[3] = 16'h0000;
    c_mem[0] = 16'h4000; c_mem[1] = 16'h2000; c_mem[2] = 16'h1000;
    run(4, 3, 0, "impulse", d);
    chk("impulse_len", 64'(d), 64'd22);

    // Full-scale positive accumulation
    for (int i = 0; i < 4; i++) begin
      x_mem[i] = 16'h7fff;
      c_mem[i] = 16'h7fff;
    end
    run(4, 4, 0, "overflow", d);

    // Negative-times-negative corner
    x_mem[0] = 16'h8000;
    c_mem[0] = 16'h8000;
    run(1, 1, 0, "negcorner", d);

    // Degenerate runs
    run(0, 5, 0, "degen_n0", d);
    run(3, 0, 0, "degen_t0", d);

    // Start while busy
    for (int i = 0; i < 64; i++) begin
      x_mem[i] = 16'($urandom);
      c_mem[i] = 16'($urandom);
    end
    run(6, 5, 7, "start_busy", d);

    // Reset in the middle of MAC
    @(negedge a_clk);
    sample_count = ADDR_W'(8);
    tap_count    = TAP_W'(8);
    start        = 1'b1;
    @(negedge a_clk);
    start = 1'b0;
    @(negedge a_clk);
    chk("rst_mid_in_mac", 64'(x_rd_en), 64'd1);
    #2 a_rst = 1'b1;
    #1 chk("rst_mid_outputs", 64'({busy, done, x_rd_en, c_rd_en, y_wr_en, ovf, x_addr, c_addr, y_addr, y_data}), 64'd0);
    repeat (2) @(negedge a_clk);
    a_rst = 1'b0;
    d = 0;
    nr = 0;
    tr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge a_clk);
      if (done) d++;
      if (busy) nr++;
      if (y_wr_en) tr++;
    end
    chk("rst_mid_done", 64'(d), 64'd0);
    chk("rst_mid_busy", 64'(nr), 64'd0);
    chk("rst_mid_writes", 64'(tr), 64'd0);

    // Randomized runs, including tap counts above MAX_TAPS
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 64; i++) begin
        x_mem[i] = 16'($urandom);
        c_mem[i] = 16'($urandom);
      end
      nr = $urandom_range(1, 24);
      tr = (r == 3) ? 70 : $urandom_range(1, 66);
      mr = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 4) : 0;
      run(nr, tr, mr, "random", d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
